// File: rtl/sipo_rx_pkg.sv
// -----------------------------------------------------------------------------
// sipo_rx_pkg
// Shared constants for the SIPO frame receiver: FSM state encoding and
// serial line levels.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sipo_rx_pkg;

    // state      | meaning
    // -----------+----------------------------------------------
    // ST_IDLE    | line idle, waiting for a start bit
    // ST_DATA    | shifting DATA_W data bits, LSB first
    // ST_PARITY  | sampling the parity bit (PARITY_CHECK_EN only)
    // ST_STOP    | sampling the stop bit, frame completes here
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage : sipo_rx_pkg

// File: rtl/sipo_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver_if
// Bundles the serial line, the output word handshake and the status flags of
// the SIPO frame receiver.
//   serial_in  : serial line, one bit per clk
//   data_out   : received word, LSB = first data bit
//   data_valid : data_out holds an unconsumed word
//   data_ready : consumer accepts data_out
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : one-cycle pulse when a completed frame is dropped
//   parity_err : parity flag, qualified by data_valid
// Modports: master = line driver / consumer side, slave = receiver.
// -----------------------------------------------------------------------------
interface sipo_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    modport master (
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  parity_err
    );

    modport slave (
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output parity_err
    );
endinterface : sipo_frame_receiver_if

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// DATA_W-bit serial-in parallel-out shift register. Bits enter at the MSB and
// move toward the LSB, so after DATA_W enabled cycles the first bit received
// sits in bit 0.
//   clk        : clock
//   rst        : asynchronous active-low reset (clears the register)
//   i_shift_en : shift one bit in this cycle
//   i_bit      : serial bit to shift in
//   o_q        : parallel contents
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_shift_en,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {i_bit, r_q[DATA_W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule : sipo_shift_reg

// File: rtl/sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver
// Receives frames of: start bit (1), DATA_W data bits LSB first, optional
// parity bit, stop bit (0). The line idles at 0. Completed words are held in
// a one-entry output buffer with a valid/ready handshake.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-low reset
//   bus : sipo_frame_receiver_if.slave (serial_in, data_ready in;
//         data_out, data_valid, frame_err, overrun, parity_err out)
// Build option: define PARITY_CHECK_EN to expect an even-parity bit after the
// data bits; without it parity_err is tied to 0.
// -----------------------------------------------------------------------------
module sipo_frame_receiver
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_frame_receiver_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_frame_err;
    logic              r_overrun;

    logic [DATA_W-1:0] w_shift_q;
    logic              w_shift_en;
    logic              w_stop_cycle;
    logic              w_stop_ok;
    logic              w_xfer;
    logic              w_load;
    logic              w_drop;

    sipo_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (w_shift_en),
        .i_bit      (bus.serial_in),
        .o_q        (w_shift_q)
    );

    assign w_shift_en   = (r_state == ST_DATA);
    assign w_stop_cycle = (r_state == ST_STOP);
    assign w_stop_ok    = w_stop_cycle && (bus.serial_in == STOP_BIT);
    assign w_xfer       = r_data_valid && bus.data_ready;
    // A completing frame loads if the buffer is empty or is being emptied
    // on this same edge; otherwise it is dropped.
    assign w_load       = w_stop_ok && (!r_data_valid || w_xfer);
    assign w_drop       = w_stop_ok && r_data_valid && !bus.data_ready;

    // Bit counter runs down from DATA_W-1; terminal count 0 ends the data phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.serial_in == START_BIT) begin
                        r_state <= ST_DATA;
                        r_cnt   <= CNT_W'(DATA_W - 1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == '0) begin
`ifdef PARITY_CHECK_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: r_state <= ST_STOP;
`endif
                // A bad stop bit also lands in IDLE, so it is never taken
                // as the start of a new frame.
                ST_STOP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_stop_cycle && (bus.serial_in != STOP_BIT);
            r_overrun   <= w_drop;
            if (w_load) begin
                r_data_out   <= w_shift_q;
                r_data_valid <= 1'b1;
            end else if (w_xfer) begin
                r_data_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_par_bit;
    logic r_parity_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == ST_PARITY) begin
                r_par_bit <= bus.serial_in;
            end
            // Even parity over data plus parity bit; an odd total flags an error.
            if (w_load) begin
                r_parity_err <= ^{w_shift_q, r_par_bit};
            end
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

endmodule : sipo_frame_receiver

// File: tb/tb_sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_receiver
// Self-checking bench for sipo_frame_receiver with DATA_W = 8. Define
// PARITY_CHECK_EN for both bench and RTL to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_sipo_frame_receiver;
    import sipo_rx_pkg::*;

    localparam int DW = 8;

    logic clk;
    logic rst;

    sipo_frame_receiver_if #(.DATA_W(DW)) bus ();

    sipo_frame_receiver #(
        .DATA_W (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        logic          exp_ferr;
        logic          exp_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par,
                              input logic stop, input logic rdy_at_stop);
        bus.serial_in = START_BIT;
        tick();
        for (int i = 0; i < DW; i++) begin
            bus.serial_in = d[i];
            tick();
        end
`ifdef PARITY_CHECK_EN
        bus.serial_in = par;
        tick();
`else
        if (par === 1'bz) bus.serial_in = IDLE_LEVEL;
`endif
        bus.serial_in = stop;
        if (rdy_at_stop) bus.data_ready = 1'b1;
        tick();
        bus.serial_in = IDLE_LEVEL;
    endtask

    task automatic drain();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("drain_valid_low", 32'(bus.data_valid), 32'd0);
    endtask

    // Transfers happen on the posedge; inputs are stable at the prior negedge.
    always @(negedge clk) begin
        if (rst && bus.data_valid && bus.data_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got 0x%0h expected no transfer", bus.data_out);
            end else begin
                chk("sb_word", 32'(bus.data_out), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic flags_seen;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        bus.serial_in  = IDLE_LEVEL;
        bus.data_ready = 1'b0;
        tick();
        tick();
        chk("rst_data_out",   32'(bus.data_out),   32'd0);
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
        chk("rst_overrun",    32'(bus.overrun),    32'd0);
        chk("rst_parity_err", 32'(bus.parity_err), 32'd0);
        rst = 1'b1;

        // Table: isolated frames, held with data_ready=0, then drained.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_valid) sb_q.push_back(vecs[v].data);
            bus.serial_in = START_BIT;
            tick();
            for (int i = 0; i < DW; i++) begin
                bus.serial_in = vecs[v].data[i];
                tick();
            end
`ifdef PARITY_CHECK_EN
            bus.serial_in = ^vecs[v].data;
            tick();
`endif
            chk("pre_stop_valid", 32'(bus.data_valid), 32'd0);
            bus.serial_in = vecs[v].stop;
            tick();
            bus.serial_in = IDLE_LEVEL;
            chk("vec_frame_err",  32'(bus.frame_err),  32'(vecs[v].exp_ferr));
            chk("vec_data_valid", 32'(bus.data_valid), 32'(vecs[v].exp_valid));
            chk("vec_overrun",    32'(bus.overrun),    32'd0);
            chk("vec_parity_err", 32'(bus.parity_err), 32'd0);
            if (vecs[v].exp_valid) chk("vec_data_out", 32'(bus.data_out), 32'(vecs[v].data));
            tick();
            chk("vec_ferr_pulse", 32'(bus.frame_err), 32'd0);
            for (int k = 0; k < DW + 3; k++) tick();
            chk("vec_hold_valid", 32'(bus.data_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk("vec_hold_data", 32'(bus.data_out), 32'(vecs[v].data));
                drain();
            end
        end

        // Overrun: 0x11 then 0x22 back-to-back, consumer stalled.
        sb_q.push_back(8'h11);
        send_frame(8'h11, ^8'h11, STOP_BIT, 1'b0);
        chk("ovr_first_valid", 32'(bus.data_valid), 32'd1);
        chk("ovr_first_flag",  32'(bus.overrun),    32'd0);
        send_frame(8'h22, ^8'h22, STOP_BIT, 1'b0);
        chk("ovr_pulse",    32'(bus.overrun),    32'd1);
        chk("ovr_kept",     32'(bus.data_out),   32'h11);
        chk("ovr_valid",    32'(bus.data_valid), 32'd1);
        tick();
        chk("ovr_pulse_end", 32'(bus.overrun), 32'd0);
        drain();

        // Coincident completion and transfer.
        sb_q.push_back(8'h11);
        send_frame(8'h11, ^8'h11, STOP_BIT, 1'b0);
        sb_q.push_back(8'h22);
        send_frame(8'h22, ^8'h22, STOP_BIT, 1'b1);
        bus.data_ready = 1'b0;
        chk("coin_valid",   32'(bus.data_valid), 32'd1);
        chk("coin_data",    32'(bus.data_out),   32'h22);
        chk("coin_overrun", 32'(bus.overrun),    32'd0);
        tick();
        chk("coin_overrun_next", 32'(bus.overrun), 32'd0);
        drain();

        // Reset mid-frame with a word pending.
        send_frame(8'h33, ^8'h33, STOP_BIT, 1'b0);
        bus.serial_in = START_BIT;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = 1'b1;
            tick();
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_data_out",   32'(bus.data_out),   32'd0);
        chk("mid_rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("mid_rst_frame_err",  32'(bus.frame_err),  32'd0);
        chk("mid_rst_overrun",    32'(bus.overrun),    32'd0);
        chk("mid_rst_parity_err", 32'(bus.parity_err), 32'd0);
        bus.serial_in = IDLE_LEVEL;
        tick();
        tick();
        rst = 1'b1;
        flags_seen = 1'b0;
        for (int k = 0; k < DW + 4; k++) begin
            tick();
            flags_seen |= bus.frame_err | bus.overrun | bus.data_valid;
        end
        chk("post_rst_quiet", 32'(flags_seen), 32'd0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, ^8'h5A, STOP_BIT, 1'b0);
        chk("post_rst_valid", 32'(bus.data_valid), 32'd1);
        chk("post_rst_data",  32'(bus.data_out),   32'h5A);
        drain();

`ifdef PARITY_CHECK_EN
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, STOP_BIT, 1'b0);
        chk("par_good_err",  32'(bus.parity_err), 32'd0);
        chk("par_good_data", 32'(bus.data_out),   32'h07);
        drain();
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, STOP_BIT, 1'b0);
        chk("par_bad_err",   32'(bus.parity_err), 32'd1);
        chk("par_bad_data",  32'(bus.data_out),   32'h07);
        chk("par_bad_valid", 32'(bus.data_valid), 32'd1);
        tick();
        tick();
        chk("par_bad_hold",  32'(bus.parity_err), 32'd1);
        drain();
`endif

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sipo_frame_receiver

// File: doc/sipo_frame_receiver.md
SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, number of data bits per frame (range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port serial_in, input, 1 bit: serial line, one bit per clk, driven by the upstream SISO stage's serial_out.
REQ-005 The block SHALL have port data_out, output, DATA_W bits: received word, LSB = first data bit.
REQ-006 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-007 The block SHALL have port data_ready, input, 1 bit: consumer accepts data_out.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-010 The block SHALL have port parity_err, output, 1 bit: parity flag qualified by data_valid; tied 0 without the macro.

Function
REQ-011 Frame format SHALL be: idle 0; start bit 1; DATA_W data bits LSB first; optional parity bit; stop bit 0.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP; PARITY is present only with the macro.
REQ-013 IDLE SHALL go to DATA when serial_in=1; otherwise it stays in IDLE.
REQ-014 DATA SHALL shift one bit per cycle and leave after exactly DATA_W cycles, via a bit counter of $clog2(DATA_W) bits, for PARITY (macro) or STOP.
REQ-015 PARITY SHALL sample one bit and go to STOP.
REQ-016 STOP SHALL always return to IDLE, so back-to-back frames have a start bit on the cycle after the stop bit.
REQ-017 Stop bit = 0 SHALL complete the frame.
REQ-018 Stop bit = 1 SHALL discard the word, pulse frame_err on the next cycle, and not treat that bit as a new start bit.
REQ-019 On completion, data_out SHALL load the word and data_valid SHALL rise on the cycle after the stop-bit cycle (latency: stop bit to valid = 1 clk).
REQ-020 A transfer SHALL occur when data_valid and data_ready are both 1; data_valid then falls unless a new word is loaded in the same cycle.
REQ-021 While data_valid=1 and data_ready=0, data_out and parity_err SHALL remain stable.
REQ-022 If completion and transfer coincide, the new word SHALL load, data_valid SHALL stay 1, and overrun SHALL NOT pulse.
REQ-023 If completion occurs with data_valid=1 and data_ready=0, the new word SHALL be dropped, the old word kept, and overrun pulsed for one cycle.
REQ-024 A frame_err frame SHALL NOT affect data_out or data_valid.

Reset
REQ-025 While rst=0, the block SHALL set state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overrun=0, parity_err=0.
REQ-026 A reset mid-frame SHALL abandon the frame with no error pulse.
REQ-027 After rst deasserts, the first cycle SHALL sample serial_in in IDLE.

Configuration
REQ-028 Macro PARITY_CHECK_EN SHALL control parity.
REQ-029 With PARITY_CHECK_EN defined: a parity bit SHALL follow the data bits; even parity over data plus parity bit; parity_err = 1 if odd, loaded with data_out; the frame is still delivered.
REQ-030 Without PARITY_CHECK_EN: there SHALL be no parity bit and no PARITY state; parity_err SHALL be constant 0.

Structure
REQ-031 Package sipo_rx_pkg SHALL hold the FSM state encoding and the constants START_BIT=1, STOP_BIT=0 and IDLE_LEVEL=0.
REQ-032 Sub-module sipo_shift_reg (DATA_W-bit, shift-enable, LSB-first fill) SHALL hold the data shift path; the FSM, handshake buffer and flags stay in the top module.

Verification
REQ-033 Bench SHALL cover, with DATA_W=8, no macro: line 1,1,0,1,0,0,1,0,1,0 -> data_out=0xA5, data_valid=1 on the cycle after the stop bit; held until data_ready=1.
REQ-034 Bench SHALL cover a bad stop: same frame with stop bit 1 -> frame_err pulses 1 cycle, data_valid stays 0, and the next valid frame 0x3C is received correctly.
REQ-035 Bench SHALL cover overrun: frames 0x11 then 0x22 back-to-back with data_ready=0 -> data_out=0x11 retained, overrun pulses once at the 0x22 completion.
REQ-036 Bench SHALL cover coincident events: data_ready=1 on the completion cycle of the second frame -> 0x11 transferred, data_out=0x22, data_valid stays 1, no overrun.
REQ-037 Bench SHALL cover the macro: with PARITY_CHECK_EN, frame 0x07 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1, data_out=0x07.
REQ-038 Bench SHALL cover reset mid-frame: rst=0 after 4 data bits -> all outputs 0, no flags; the next frame 0x5A is received correctly.
